// File: rtl/sr_lock_pkg.sv
// sr_lock_pkg: shared types and constants for the sr_lock_arbiter block.
// The optional hold-timeout feature is enabled with the SR_LOCK_TIMEOUT_EN macro.
package sr_lock_pkg;

    // Lock FSM states; encoding is fixed so debug tooling can decode it.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOCKED  = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    // Default number of requesters.
    localparam int N_REQ_DEFAULT   = 4;

    // Default maximum number of cycles one owner may hold the lock.
    localparam int TIMEOUT_DEFAULT = 16;

    // Width of the hold counter; bounds the largest usable TIMEOUT.
    localparam int CNT_W           = 8;

endpackage : sr_lock_pkg

// File: rtl/sr_lock_arbiter_picker.sv
// rr_priority_picker: purely combinational round-robin selector.
// The search starts at rr_ptr, wraps modulo N_REQ, and the first set req bit
// wins. Implemented as "lowest set bit at or above rr_ptr, else lowest set bit
// overall", which is equivalent to a rotating search without variable rotates.
module rr_priority_picker #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] rr_ptr,
    output logic [N_REQ-1:0]         winner,
    output logic                     valid
);

    logic [N_REQ-1:0] w_upper;
    logic [N_REQ-1:0] w_upper_pick;
    logic [N_REQ-1:0] w_lower_pick;

    // Returns a one-hot vector marking the lowest set bit of v (zero if none).
    function automatic logic [N_REQ-1:0] lowest_set(input logic [N_REQ-1:0] v);
        logic [N_REQ-1:0] r;
        logic             f;
        r = '0;
        f = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (v[i] && !f) begin
                r[i] = 1'b1;
                f    = 1'b1;
            end
        end
        return r;
    endfunction

    // Keep only requests at or above the round-robin pointer.
    always_comb begin
        w_upper = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_upper[i] = req[i] && (i >= int'(rr_ptr));
        end
    end

    assign w_upper_pick = lowest_set(w_upper);
    assign w_lower_pick = lowest_set(req);

    // Upper half wins if populated; otherwise the search has wrapped.
    assign winner = (|w_upper) ? w_upper_pick : w_lower_pick;
    assign valid  = |req;

endmodule : rr_priority_picker

// File: rtl/sr_lock_arbiter.sv
// sr_lock_arbiter: round-robin mutual-exclusion lock with a one-cycle holdoff
// after every release. All outputs come straight from registers.
// Define SR_LOCK_TIMEOUT_EN to add an 8-bit hold counter that forces release
// after TIMEOUT cycles and pulses timeout_err; without it timeout_err is 0.
//
// Request/release semantics: req is a level held by a requester that wants
// the lock; the grant arrives one cycle after req is seen in IDLE. rel is a
// one-cycle strobe honoured only from the current owner; release beats a
// simultaneous req from that owner. No preemption while LOCKED.
module sr_lock_arbiter
    import sr_lock_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         rel,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     q,
    output logic                     qbar,
    output logic                     timeout_err,
    output state_t                   dbg_state,
    output logic [$clog2(N_REQ)-1:0] dbg_rr_ptr
);

    localparam int PTR_W = $clog2(N_REQ);

    // Reject parameter values outside the supported range at elaboration.
    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 2 || TIMEOUT > ((1 << CNT_W) - 1)) begin : g_bad_param
        $error("sr_lock_arbiter: N_REQ must be 2..8 and TIMEOUT 2..255");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic [N_REQ-1:0]   r_grant;
    logic [N_REQ-1:0]   w_grant_nxt;
    logic [PTR_W-1:0]   r_owner;
    logic [PTR_W-1:0]   w_owner_nxt;
    logic               r_q;
    logic               w_q_nxt;
    logic               r_qbar;
    logic               r_timeout_err;
    logic               w_timeout_err_nxt;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   w_rr_ptr_nxt;

    logic [N_REQ-1:0]   w_winner;
    logic               w_win_valid;
    logic [PTR_W-1:0]   w_win_idx;
    logic [PTR_W-1:0]   w_win_idx_inc;

`ifdef SR_LOCK_TIMEOUT_EN
    logic [CNT_W-1:0]   r_hold_cnt;
    logic [CNT_W-1:0]   w_hold_cnt_nxt;
`endif

    rr_priority_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req    (req),
        .rr_ptr (r_rr_ptr),
        .winner (w_winner),
        .valid  (w_win_valid)
    );

    // Convert the one-hot winner into an index for owner and rr_ptr.
    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_winner[i]) begin
                w_win_idx = PTR_W'(i);
            end
        end
    end

    // Pointer moves one past the winner, wrapping at N_REQ-1.
    assign w_win_idx_inc = (w_win_idx == PTR_W'(N_REQ - 1)) ? '0 : (w_win_idx + 1'b1);

    // Next-state and next-output logic for the lock FSM.
    always_comb begin
        w_state_nxt       = r_state;
        w_grant_nxt       = r_grant;
        w_owner_nxt       = r_owner;
        w_q_nxt           = r_q;
        w_rr_ptr_nxt      = r_rr_ptr;
        w_timeout_err_nxt = 1'b0;
`ifdef SR_LOCK_TIMEOUT_EN
        w_hold_cnt_nxt    = r_hold_cnt;
`endif
        case (r_state)
            IDLE: begin
                if (w_win_valid) begin
                    w_state_nxt    = LOCKED;
                    w_grant_nxt    = w_winner;
                    w_owner_nxt    = w_win_idx;
                    w_q_nxt        = 1'b1;
                    w_rr_ptr_nxt   = w_win_idx_inc;
`ifdef SR_LOCK_TIMEOUT_EN
                    w_hold_cnt_nxt = '0;
`endif
                end else begin
                    w_grant_nxt = '0;
                    w_owner_nxt = '0;
                    w_q_nxt     = 1'b0;
                end
            end
            LOCKED: begin
                if (rel[r_owner]) begin
                    // Owner release; takes priority over a timeout on the same cycle.
                    w_state_nxt = HOLDOFF;
                    w_grant_nxt = '0;
                    w_owner_nxt = '0;
                    w_q_nxt     = 1'b0;
`ifdef SR_LOCK_TIMEOUT_EN
                    w_hold_cnt_nxt = '0;
                end else if (r_hold_cnt == CNT_W'(TIMEOUT - 1)) begin
                    // Owner held too long: force the lock open and flag it.
                    w_state_nxt       = HOLDOFF;
                    w_grant_nxt       = '0;
                    w_owner_nxt       = '0;
                    w_q_nxt           = 1'b0;
                    w_timeout_err_nxt = 1'b1;
                    w_hold_cnt_nxt    = '0;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + 1'b1;
`endif
                end
            end
            HOLDOFF: begin
                // One dead cycle so a releasing owner cannot instantly re-win.
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
                w_owner_nxt = '0;
                w_q_nxt     = 1'b0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
                w_owner_nxt = '0;
                w_q_nxt     = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered outputs and arbitration pointer; qbar is stored, not derived.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_grant       <= '0;
            r_owner       <= '0;
            r_q           <= 1'b0;
            r_qbar        <= 1'b1;
            r_timeout_err <= 1'b0;
            r_rr_ptr      <= '0;
        end else begin
            r_grant       <= w_grant_nxt;
            r_owner       <= w_owner_nxt;
            r_q           <= w_q_nxt;
            r_qbar        <= ~w_q_nxt;
            r_timeout_err <= w_timeout_err_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
        end
    end

`ifdef SR_LOCK_TIMEOUT_EN
    // Hold counter: cleared on lock entry, counts LOCKED cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold_cnt <= '0;
        end else begin
            r_hold_cnt <= w_hold_cnt_nxt;
        end
    end
`endif

    assign grant       = r_grant;
    assign owner       = r_owner;
    assign q           = r_q;
    assign qbar        = r_qbar;
    assign timeout_err = r_timeout_err;
    assign dbg_state   = r_state;
    assign dbg_rr_ptr  = r_rr_ptr;

endmodule : sr_lock_arbiter

// File: tb/tb_sr_lock_arbiter.sv
// tb_sr_lock_arbiter: table-driven and hand-sequenced checks of sr_lock_arbiter
// (N_REQ=4, TIMEOUT=16). Timeout sequences run only with SR_LOCK_TIMEOUT_EN.
module tb_sr_lock_arbiter;
    import sr_lock_pkg::*;

    localparam int W = 13;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req;
    logic [3:0]   rel;
    logic [3:0]   grant;
    logic [1:0]   owner;
    logic         q;
    logic         qbar;
    logic         timeout_err;
    state_t       dbg_state;
    logic [1:0]   dbg_rr_ptr;

    int           total;
    int           bad;
    logic         qcheck_en;

    logic [W-1:0] exp_q[$];

    typedef struct {
        logic       rs;
        logic [3:0] rq;
        logic [3:0] rl;
        state_t     st;
        logic [3:0] g;
        logic [1:0] o;
        logic       qv;
        logic [1:0] rr;
    } vec_t;

    vec_t vecs[17];

    sr_lock_arbiter #(
        .N_REQ   (4),
        .TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .rel         (rel),
        .grant       (grant),
        .owner       (owner),
        .q           (q),
        .qbar        (qbar),
        .timeout_err (timeout_err),
        .dbg_state   (dbg_state),
        .dbg_rr_ptr  (dbg_rr_ptr)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // qbar must be the complement of q on every cycle of the run.
    always @(negedge clk) begin
        if (qcheck_en) begin
            total++;
            if (qbar !== ~q) begin
                bad++;
                $display("FAIL qbar_vs_q: got q=%b qbar=%b, want qbar=%b", q, qbar, ~q);
            end
        end
    end

    function automatic logic [W-1:0] ex(input state_t s, input logic [3:0] g,
                                        input logic [1:0] o, input logic qv,
                                        input logic te, input logic [1:0] rr);
        return {s, g, o, qv, ~qv, te, rr};
    endfunction

    // Pop the oldest expectation and compare it to the DUT outputs.
    task automatic check(input string name);
        logic [W-1:0] e;
        logic [W-1:0] a;
        e = exp_q.pop_front();
        a = {dbg_state, grant, owner, q, qbar, timeout_err, dbg_rr_ptr};
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got st=%0d g=%b o=%0d q=%b qb=%b te=%b rr=%0d, want st=%0d g=%b o=%0d q=%b qb=%b te=%b rr=%0d",
                     name, a[12:11], a[10:7], a[6:5], a[4], a[3], a[2], a[1:0],
                     e[12:11], e[10:7], e[6:5], e[4], e[3], e[2], e[1:0]);
        end
    endtask

    // Drive one cycle of inputs, queue the expectation, check after the edge.
    task automatic step(input logic rs, input logic [3:0] rq, input logic [3:0] rl,
                        input logic [W-1:0] e, input string name);
        rst_n = rs;
        req   = rq;
        rel   = rl;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check(name);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        qcheck_en = 1'b0;
        rst_n     = 1'b0;
        req       = 4'b0000;
        rel       = 4'b0000;

        // rs, req, rel, state, grant, owner, q, rr_ptr
        vecs[0]  = '{1'b0, 4'b0000, 4'b0000, IDLE,    4'b0000, 2'd0, 1'b0, 2'd0};
        vecs[1]  = '{1'b1, 4'b0100, 4'b0000, LOCKED,  4'b0100, 2'd2, 1'b1, 2'd3};
        vecs[2]  = '{1'b1, 4'b0100, 4'b0000, LOCKED,  4'b0100, 2'd2, 1'b1, 2'd3};
        vecs[3]  = '{1'b1, 4'b0000, 4'b0000, LOCKED,  4'b0100, 2'd2, 1'b1, 2'd3};
        vecs[4]  = '{1'b1, 4'b1011, 4'b0001, LOCKED,  4'b0100, 2'd2, 1'b1, 2'd3};
        vecs[5]  = '{1'b1, 4'b0100, 4'b0100, HOLDOFF, 4'b0000, 2'd0, 1'b0, 2'd3};
        vecs[6]  = '{1'b1, 4'b1111, 4'b0000, IDLE,    4'b0000, 2'd0, 1'b0, 2'd3};
        vecs[7]  = '{1'b1, 4'b1111, 4'b0000, LOCKED,  4'b1000, 2'd3, 1'b1, 2'd0};
        vecs[8]  = '{1'b1, 4'b1111, 4'b1000, HOLDOFF, 4'b0000, 2'd0, 1'b0, 2'd0};
        vecs[9]  = '{1'b1, 4'b1111, 4'b0000, IDLE,    4'b0000, 2'd0, 1'b0, 2'd0};
        vecs[10] = '{1'b1, 4'b1111, 4'b0000, LOCKED,  4'b0001, 2'd0, 1'b1, 2'd1};
        vecs[11] = '{1'b0, 4'b1000, 4'b0000, IDLE,    4'b0000, 2'd0, 1'b0, 2'd0};
        vecs[12] = '{1'b1, 4'b0000, 4'b0000, IDLE,    4'b0000, 2'd0, 1'b0, 2'd0};
        vecs[13] = '{1'b1, 4'b0110, 4'b0000, LOCKED,  4'b0010, 2'd1, 1'b1, 2'd2};
        vecs[14] = '{1'b1, 4'b0110, 4'b0100, LOCKED,  4'b0010, 2'd1, 1'b1, 2'd2};
        vecs[15] = '{1'b1, 4'b0110, 4'b0010, HOLDOFF, 4'b0000, 2'd0, 1'b0, 2'd2};
        vecs[16] = '{1'b1, 4'b0000, 4'b0000, IDLE,    4'b0000, 2'd0, 1'b0, 2'd2};

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].rs, vecs[i].rq, vecs[i].rl,
                 ex(vecs[i].st, vecs[i].g, vecs[i].o, vecs[i].qv, 1'b0, vecs[i].rr),
                 $sformatf("vec%0d", i));
            qcheck_en = 1'b1;
        end

        // Round-robin rotation with all requesters active: 0,1,2,3,0.
        step(1'b0, 4'b0000, 4'b0000, ex(IDLE, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0), "rot_reset");
        for (int k = 0; k < 5; k++) begin
            logic [1:0] o;
            logic [1:0] nx;
            logic [3:0] oh;
            o  = 2'(k % 4);
            nx = 2'((k + 1) % 4);
            oh = 4'b0001 << o;
            step(1'b1, 4'b1111, 4'b0000, ex(LOCKED, oh, o, 1'b1, 1'b0, nx), $sformatf("rot%0d_grant", k));
            step(1'b1, 4'b1111, 4'b0000, ex(LOCKED, oh, o, 1'b1, 1'b0, nx), $sformatf("rot%0d_hold1", k));
            step(1'b1, 4'b1111, 4'b0000, ex(LOCKED, oh, o, 1'b1, 1'b0, nx), $sformatf("rot%0d_hold2", k));
            step(1'b1, 4'b1111, oh,      ex(HOLDOFF, 4'b0000, 2'd0, 1'b0, 1'b0, nx), $sformatf("rot%0d_rel", k));
            step(1'b1, 4'b1111, 4'b0000, ex(IDLE, 4'b0000, 2'd0, 1'b0, 1'b0, nx), $sformatf("rot%0d_idle", k));
        end

        // Reset while owner 3 holds the lock, then regrant once reset lifts.
        step(1'b1, 4'b1000, 4'b0000, ex(LOCKED, 4'b1000, 2'd3, 1'b1, 1'b0, 2'd0), "rst_lock3");
        step(1'b0, 4'b1000, 4'b0000, ex(IDLE,   4'b0000, 2'd0, 1'b0, 1'b0, 2'd0), "rst_mid_lock");
        step(1'b1, 4'b1000, 4'b0000, ex(LOCKED, 4'b1000, 2'd3, 1'b1, 1'b0, 2'd0), "rst_regrant");
        step(1'b1, 4'b0000, 4'b1000, ex(HOLDOFF, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0), "rst_release");
        step(1'b1, 4'b0000, 4'b0000, ex(IDLE,   4'b0000, 2'd0, 1'b0, 1'b0, 2'd0), "rst_idle");

`ifdef SR_LOCK_TIMEOUT_EN
        // Owner 0 never releases: forced release 16 cycles after grant.
        step(1'b1, 4'b0001, 4'b0000, ex(LOCKED, 4'b0001, 2'd0, 1'b1, 1'b0, 2'd1), "to_grant");
        for (int c = 1; c < 16; c++) begin
            step(1'b1, 4'b0000, 4'b0000, ex(LOCKED, 4'b0001, 2'd0, 1'b1, 1'b0, 2'd1), $sformatf("to_hold%0d", c));
        end
        step(1'b1, 4'b0000, 4'b0000, ex(HOLDOFF, 4'b0000, 2'd0, 1'b0, 1'b1, 2'd1), "to_fire");
        step(1'b1, 4'b0000, 4'b0000, ex(IDLE, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd1), "to_after");

        // Release arriving on the timeout cycle is an ordinary release.
        step(1'b1, 4'b0010, 4'b0000, ex(LOCKED, 4'b0010, 2'd1, 1'b1, 1'b0, 2'd2), "tor_grant");
        for (int c = 1; c < 16; c++) begin
            step(1'b1, 4'b0010, 4'b0000, ex(LOCKED, 4'b0010, 2'd1, 1'b1, 1'b0, 2'd2), $sformatf("tor_hold%0d", c));
        end
        step(1'b1, 4'b0010, 4'b0010, ex(HOLDOFF, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd2), "tor_rel");
        step(1'b1, 4'b0000, 4'b0000, ex(IDLE, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd2), "tor_idle");
`else
        // Without the timeout feature the lock is held indefinitely.
        step(1'b1, 4'b0001, 4'b0000, ex(LOCKED, 4'b0001, 2'd0, 1'b1, 1'b0, 2'd1), "nto_grant");
        for (int c = 1; c < 24; c++) begin
            step(1'b1, 4'b0000, 4'b0000, ex(LOCKED, 4'b0001, 2'd0, 1'b1, 1'b0, 2'd1), $sformatf("nto_hold%0d", c));
        end
        step(1'b1, 4'b0000, 4'b0001, ex(HOLDOFF, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd1), "nto_rel");
`endif

        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL exp_q_drain: got %0d entries left, want 0", exp_q.size());
        end
        total++;

        qcheck_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sr_lock_arbiter
